timer_multi: RTL and testbench



---
 rtl/timer_multi.sv | 192 +++++++++++++++++++
 tb/tb_timer_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// Multi-channel prescaled down-counter timer on the D16i 16-bit register bus.
// A write is a single-cycle strobe (we) and lands at that posedge; reads are a combinational decode of addr.
module timer_multi #(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 16,
  parameter logic [15:0] BASE_GLOBAL = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic [15:0] addr,
  input  logic        we,
  output logic [15:0] dout,
  output logic        irq
);

  localparam logic [15:0] CHAN_END = 16'(4 * CHANNELS);

  // Per-channel control bits
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] mode_q, mode_d;

  // Per-channel datapath registers
  logic [WIDTH-1:0] prescale_q [CHANNELS];
  logic [WIDTH-1:0] prescale_d [CHANNELS];
  logic [WIDTH-1:0] reload_q   [CHANNELS];
  logic [WIDTH-1:0] reload_d   [CHANNELS];
  logic [WIDTH-1:0] count_q    [CHANNELS];
  logic [WIDTH-1:0] count_d    [CHANNELS];
  logic [WIDTH-1:0] pcnt_q     [CHANNELS];
  logic [WIDTH-1:0] pcnt_d     [CHANNELS];

  // Global interrupt registers
  logic [CHANNELS-1:0] irq_status_q, irq_status_d;
  logic [CHANNELS-1:0] irq_en_q, irq_en_d;

  // Address decode
  logic       chan_hit;
  logic [2:0] chan_sel;
  logic [1:0] reg_sel;
  logic       sts_wr;
  logic       ien_wr;

  assign chan_hit = (addr < CHAN_END);
  assign chan_sel = addr[4:2];
  assign reg_sel  = addr[1:0];
  assign sts_wr   = we && (addr == BASE_GLOBAL);
  assign ien_wr   = we && (addr == BASE_GLOBAL + 16'd1);

  logic [CHANNELS-1:0] ctrl_wr;
  logic [CHANNELS-1:0] pre_wr;
  logic [CHANNELS-1:0] rel_wr;
  logic [CHANNELS-1:0] load_wr;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] expire;

  always_comb begin
    ctrl_wr = '0;
    pre_wr  = '0;
    rel_wr  = '0;
    load_wr = '0;
    tick    = '0;
    expire  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_wr[c] = we && chan_hit && (chan_sel == 3'(c)) && (reg_sel == 2'd0);
      pre_wr[c]  = we && chan_hit && (chan_sel == 3'(c)) && (reg_sel == 2'd1);
      rel_wr[c]  = we && chan_hit && (chan_sel == 3'(c)) && (reg_sel == 2'd2);
      load_wr[c] = ctrl_wr[c] && din[2];
      tick[c]    = en_q[c] && (pcnt_q[c] == prescale_q[c]);
      // A LOAD in the same cycle swallows the tick, including its expiry.
      expire[c]  = tick[c] && (count_q[c] == '0) && !load_wr[c];
    end
  end

  // Next-state for every channel
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      en_d[c]       = en_q[c];
      mode_d[c]     = mode_q[c];
      prescale_d[c] = prescale_q[c];
      reload_d[c]   = reload_q[c];
      count_d[c]    = count_q[c];
      pcnt_d[c]     = pcnt_q[c];

      if (tick[c]) begin
        pcnt_d[c] = '0;
        if (count_q[c] != '0) begin
          count_d[c] = count_q[c] - 1'b1;
        end else if (mode_q[c]) begin
          count_d[c] = reload_q[c];
        end else begin
          en_d[c] = 1'b0;
        end
      end else if (en_q[c]) begin
        pcnt_d[c] = pcnt_q[c] + 1'b1;
      end

      if (pre_wr[c]) begin
        prescale_d[c] = din[WIDTH-1:0];
        pcnt_d[c]     = '0;
      end

      if (rel_wr[c]) begin
        reload_d[c] = din[WIDTH-1:0];
      end

      // Explicit CTRL writes override a one-shot self-disable in the same cycle.
      if (ctrl_wr[c]) begin
        en_d[c]   = din[0];
        mode_d[c] = din[1];
        if (din[0] && !en_q[c]) begin
          pcnt_d[c] = '0;
        end
      end

      if (load_wr[c]) begin
        count_d[c] = reload_q[c];
        pcnt_d[c]  = '0;
      end

      if (!en_d[c]) begin
        pcnt_d[c] = '0;
      end
    end
  end

  // Set wins over a simultaneous write-1-to-clear.
  always_comb begin
    irq_status_d = irq_status_q;
    irq_en_d     = irq_en_q;
    if (sts_wr) begin
      irq_status_d = irq_status_q & ~din[CHANNELS-1:0];
    end
    irq_status_d = irq_status_d | expire;
    if (ien_wr) begin
      irq_en_d = din[CHANNELS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= '0;
      mode_q       <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        prescale_q[c] <= '0;
        reload_q[c]   <= '0;
        count_q[c]    <= '0;
        pcnt_q[c]     <= '0;
      end
    end else begin
      en_q         <= en_d;
      mode_q       <= mode_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      for (int c = 0; c < CHANNELS; c++) begin
        prescale_q[c] <= prescale_d[c];
        reload_q[c]   <= reload_d[c];
        count_q[c]    <= count_d[c];
        pcnt_q[c]     <= pcnt_d[c];
      end
    end
  end

  // Read mux; LOAD is write-only so CTRL only returns MODE and EN.
  logic [15:0] rdata;

  always_comb begin
    rdata = '0;
    if (chan_hit) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (chan_sel == 3'(c)) begin
          case (reg_sel)
            2'd0:    rdata[1:0]       = {mode_q[c], en_q[c]};
            2'd1:    rdata[WIDTH-1:0] = prescale_q[c];
            2'd2:    rdata[WIDTH-1:0] = reload_q[c];
            default: rdata[WIDTH-1:0] = count_q[c];
          endcase
        end
      end
    end else if (addr == BASE_GLOBAL) begin
      rdata[CHANNELS-1:0] = irq_status_q;
    end else if (addr == BASE_GLOBAL + 16'd1) begin
      rdata[CHANNELS-1:0] = irq_en_q;
    end
  end

  assign dout = rdata;
  assign irq  = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: register access, periodic/one-shot timing, masking, pause, LOAD collision, reset.
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] din;
  logic [15:0] addr;
  logic [15:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timer_multi #(
    .CHANNELS    (4),
    .WIDTH       (16),
    .BASE_GLOBAL (16'h0040)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .addr (addr),
    .we   (we),
    .dout (dout),
    .irq  (irq)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    we   = 1'b0;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk(tag, {15'd0, irq}, {15'd0, exp});
  endtask

  // Write lands at the next posedge; returns 1 time unit after it.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 16'h0000;
    din  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int a = 0; a < 16; a++) rd(16'(a), 16'h0000, "reset_chan_reg");
    rd(16'h0040, 16'h0000, "reset_irq_status");
    rd(16'h0041, 16'h0000, "reset_irq_en");
    rd(16'h0030, 16'h0000, "reset_unmapped");
    chk_irq(1'b0, "reset_irq");

    // Periodic ch0: PRESCALE=2 RELOAD=3 -> expiry every 12 cycles
    wr(16'h0001, 16'd2);
    wr(16'h0002, 16'd3);
    wr(16'h0041, 16'h0001);
    wr(16'h0000, 16'h0007);
    rd(16'h0000, 16'h0003, "per_ctrl_readback");
    step(11);
    rd(16'h0040, 16'h0000, "per_status_before");
    rd(16'h0003, 16'h0000, "per_count_zero");
    chk_irq(1'b0, "per_irq_before");
    step(1);
    rd(16'h0040, 16'h0001, "per_status_set");
    chk_irq(1'b1, "per_irq_high");
    wr(16'h0040, 16'h0001);
    rd(16'h0040, 16'h0000, "per_status_w1c");
    chk_irq(1'b0, "per_irq_w1c");
    step(10);
    rd(16'h0040, 16'h0000, "per_status_second_before");
    step(1);
    rd(16'h0040, 16'h0001, "per_status_second_set");
    rd(16'h0003, 16'h0003, "per_count_reloaded");
    wr(16'h0000, 16'h0000);
    wr(16'h0040, 16'h0001);
    rd(16'h0040, 16'h0000, "per_cleanup");

    // One-shot ch1: PRESCALE=0 RELOAD=5 -> single expiry 6 cycles after the write
    wr(16'h0005, 16'd0);
    wr(16'h0006, 16'd5);
    wr(16'h0004, 16'h0005);
    rd(16'h0004, 16'h0001, "os_ctrl_load_reads0");
    step(5);
    rd(16'h0040, 16'h0000, "os_status_before");
    rd(16'h0007, 16'h0000, "os_count_at_zero");
    step(1);
    rd(16'h0040, 16'h0002, "os_status_set");
    rd(16'h0004, 16'h0000, "os_ctrl_cleared");
    rd(16'h0007, 16'h0000, "os_count_held");
    chk_irq(1'b0, "os_irq_masked");
    wr(16'h0040, 16'h0002);
    step(20);
    rd(16'h0040, 16'h0000, "os_no_reexpire");
    rd(16'h0007, 16'h0000, "os_count_still_zero");

    // ch2/ch3 identical config; PRESCALE rewrite on ch2 aligns the prescaler phases
    wr(16'h0009, 16'd1);
    wr(16'h000A, 16'd2);
    wr(16'h000D, 16'd1);
    wr(16'h000E, 16'd2);
    wr(16'h0008, 16'h0005);
    wr(16'h000C, 16'h0005);
    wr(16'h0030, 16'hFFFF);
    wr(16'h0009, 16'd1);
    rd(16'h0030, 16'h0000, "unmapped_write_ignored");
    rd(16'h000B, 16'h0001, "sim_ch2_count");
    rd(16'h000F, 16'h0001, "sim_ch3_count");
    step(3);
    rd(16'h0040, 16'h0000, "sim_status_before");
    step(1);
    rd(16'h0040, 16'h000C, "sim_status_both");
    chk_irq(1'b0, "sim_irq_masked");
    wr(16'h0041, 16'h0004);
    chk_irq(1'b1, "mask_irq_on");
    wr(16'h0040, 16'h0004);
    chk_irq(1'b0, "mask_irq_off");
    rd(16'h0040, 16'h0008, "mask_status_08");
    wr(16'h0040, 16'h0008);
    rd(16'h0040, 16'h0000, "sim_cleanup");
    rd(16'h0008, 16'h0000, "sim_ch2_ctrl_off");

    // W1C on the expiry edge keeps the bit
    wr(16'h0004, 16'h0005);
    step(5);
    wr(16'h0040, 16'h0002);
    rd(16'h0040, 16'h0002, "w1c_collision_keeps");
    wr(16'h0040, 16'h0002);
    rd(16'h0040, 16'h0000, "w1c_after");

    // Pause ch0 at COUNT=2, then resume: 3 more ticks to expiry
    wr(16'h0001, 16'd3);
    wr(16'h0002, 16'd5);
    wr(16'h0000, 16'h0005);
    step(13);
    wr(16'h0000, 16'h0000);
    rd(16'h0003, 16'h0002, "pause_count_at_stop");
    step(20);
    rd(16'h0003, 16'h0002, "pause_count_frozen");
    wr(16'h0003, 16'h0055);
    rd(16'h0003, 16'h0002, "count_write_ignored");
    wr(16'h0000, 16'h0001);
    step(11);
    rd(16'h0040, 16'h0000, "resume_status_before");
    rd(16'h0003, 16'h0000, "resume_count_zero");
    step(1);
    rd(16'h0040, 16'h0001, "resume_status_set");
    rd(16'h0000, 16'h0000, "resume_ctrl_off");
    chk_irq(1'b0, "resume_irq_masked");
    wr(16'h0040, 16'h0001);

    // LOAD on a tick edge: COUNT takes RELOAD with no decrement
    wr(16'h0041, 16'h0001);
    wr(16'h0000, 16'h0007);
    step(7);
    wr(16'h0000, 16'h0007);
    rd(16'h0003, 16'h0005, "load_wins_count");
    step(3);
    rd(16'h0003, 16'h0005, "load_count_hold");
    step(1);
    rd(16'h0003, 16'h0004, "load_next_tick");

    // Reset asserted on the expiry edge of running ch0
    step(19);
    rd(16'h0003, 16'h0000, "pre_reset_count");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd(16'h0040, 16'h0000, "rst_no_expiry");
    chk_irq(1'b0, "rst_irq_low");
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) rd(16'(a), 16'h0000, "rst_chan_reg");
    rd(16'h0041, 16'h0000, "rst_irq_en");
    step(30);
    rd(16'h0040, 16'h0000, "rst_no_later_expiry");
    rd(16'h0003, 16'h0000, "rst_count_idle");
    chk_irq(1'b0, "rst_irq_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
